// File: rtl/hazard_forward_unit.sv
// ============================================================================
// Module   : hazard_forward_unit
// Purpose  : Operand forwarding selects, load-use stall and branch squash
//            control for the 5-stage PA-RISC pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_ra_i,
  input  logic [4:0]       id_rb_i,
  input  logic             id_use_a_i,
  input  logic             id_use_b_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rf_le_i,
  input  logic             id_l_i,
  input  logic             br_taken_i,
  output logic [1:0]       a_s_o,
  output logic [1:0]       b_s_o,
  output logic             pc_le_o,
  output logic             ifid_le_o,
  output logic             nop_s_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] SEL_RP  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic             ex_v_q,  mem_v_q,  wb_v_q;
  logic             ex_we_q, mem_we_q, wb_we_q;
  logic             ex_ld_q, mem_ld_q;
  logic [4:0]       ex_rd_q, mem_rd_q, wb_rd_q;
  logic             ex_v_d, ex_we_d, ex_ld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             luh;
  logic             stall;
  logic             nop;

  // GR0 is hardwired zero, so a write to it never produces a forwardable value.
  function automatic logic f_match(input logic v, input logic we,
                                   input logic [4:0] rd, input logic [4:0] r);
    return v & we & (rd == r) & (r != 5'd0);
  endfunction

  function automatic logic [1:0] f_sel(input logic use_r, input logic [4:0] r,
                                       input logic exv, input logic exwe, input logic [4:0] exrd,
                                       input logic mv,  input logic mwe,  input logic [4:0] mrd,
                                       input logic wv,  input logic wwe,  input logic [4:0] wrd);
    if (!use_r)                        return SEL_RP;
    else if (f_match(exv, exwe, exrd, r)) return SEL_EX;
    else if (f_match(mv, mwe, mrd, r))    return SEL_MEM;
    else if (f_match(wv, wwe, wrd, r))    return SEL_WB;
    else                               return SEL_RP;
  endfunction

  assign luh = ex_ld_q &
               ((f_match(ex_v_q, ex_we_q, ex_rd_q, id_ra_i) & id_use_a_i) |
                (f_match(ex_v_q, ex_we_q, ex_rd_q, id_rb_i) & id_use_b_i));
  assign stall = luh & ~br_taken_i;
  assign nop   = stall | br_taken_i;

  assign ex_v_d  = ~nop;
  assign ex_we_d = id_rf_le_i & ~nop;
  assign ex_ld_d = id_l_i & ~nop;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_v_q   <= 1'b0;  mem_v_q  <= 1'b0;  wb_v_q  <= 1'b0;
      ex_we_q  <= 1'b0;  mem_we_q <= 1'b0;  wb_we_q <= 1'b0;
      ex_ld_q  <= 1'b0;  mem_ld_q <= 1'b0;
      ex_rd_q  <= 5'd0;  mem_rd_q <= 5'd0;  wb_rd_q <= 5'd0;
      cnt_q    <= '0;
    end else begin
      wb_v_q   <= mem_v_q;  wb_we_q  <= mem_we_q;  wb_rd_q  <= mem_rd_q;
      mem_v_q  <= ex_v_q;   mem_we_q <= ex_we_q;   mem_rd_q <= ex_rd_q;
      mem_ld_q <= ex_ld_q;
      ex_v_q   <= ex_v_d;   ex_we_q  <= ex_we_d;   ex_rd_q  <= id_rd_i;
      ex_ld_q  <= ex_ld_d;
      cnt_q    <= cnt_d;
    end
  end

  // While reset is held the front end is frozen and a bubble is forced.
  always_comb begin
    a_s_o     = SEL_RP;
    b_s_o     = SEL_RP;
    pc_le_o   = 1'b0;
    ifid_le_o = 1'b0;
    nop_s_o   = 1'b1;
    if (rst_ni) begin
      a_s_o     = f_sel(id_use_a_i, id_ra_i, ex_v_q, ex_we_q, ex_rd_q,
                        mem_v_q, mem_we_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
      b_s_o     = f_sel(id_use_b_i, id_rb_i, ex_v_q, ex_we_q, ex_rd_q,
                        mem_v_q, mem_we_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
      pc_le_o   = ~stall;
      ifid_le_o = ~stall;
      nop_s_o   = nop;
    end
  end

  assign stall_cnt_o = cnt_q;

  // Kept for pipeline-state visibility; forwarding from MEM never needs it.
  logic unused_mem_ld;
  assign unused_mem_ld = mem_ld_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
// ============================================================================
// Module   : tb_hazard_forward_unit
// Purpose  : Directed self-checking bench for hazard_forward_unit (CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_forward_unit;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_ra, id_rb, id_rd;
  logic             id_use_a, id_use_b, id_rf_le, id_l, br_taken;
  logic [1:0]       a_s, b_s;
  logic             pc_le, ifid_le, nop_s;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt;

  hazard_forward_unit #(.CNT_W(CNT_W)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .id_ra_i     (id_ra),
    .id_rb_i     (id_rb),
    .id_use_a_i  (id_use_a),
    .id_use_b_i  (id_use_b),
    .id_rd_i     (id_rd),
    .id_rf_le_i  (id_rf_le),
    .id_l_i      (id_l),
    .br_taken_i  (br_taken),
    .a_s_o       (a_s),
    .b_s_o       (b_s),
    .pc_le_o     (pc_le),
    .ifid_le_o   (ifid_le),
    .nop_s_o     (nop_s),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID-stage instruction and let combinational outputs settle.
  task automatic set_id(input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                        input logic ub, input logic [4:0] rd, input logic le,
                        input logic ld, input logic br);
    id_ra = ra; id_use_a = ua; id_rb = rb; id_use_b = ub;
    id_rd = rd; id_rf_le = le; id_l = ld; br_taken = br;
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input int pc, input int ifid, input int nop);
    chk_eq({tag, ".pc_le"},   int'(pc_le),   pc);
    chk_eq({tag, ".ifid_le"}, int'(ifid_le), ifid);
    chk_eq({tag, ".nop_s"},   int'(nop_s),   nop);
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset with random ID inputs
    for (int i = 0; i < 2; i++) begin
      set_id(5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk_ctrl("rst", 0, 0, 1);
      chk_eq("rst.a_s", int'(a_s), 0);
      chk_eq("rst.b_s", int'(b_s), 0);
      chk_eq("rst.cnt", int'(stall_cnt), 0);
      tick();
    end
    rst_n = 1'b1;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("rel", 1, 1, 0);

    // Forwarding distance: writer of r3, then readers of r3 at EX/MEM/WB/none
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk_eq("fwd.a_idle", int'(a_s), 0);
    tick();
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("fwd.ex", int'(a_s), 1);
    tick();
    chk_eq("fwd.mem", int'(a_s), 2);
    tick();
    chk_eq("fwd.wb", int'(a_s), 3);
    tick();
    chk_eq("fwd.none", int'(a_s), 0);
    // Two writers of r3: youngest (EX) wins
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("fwd.young_a", int'(a_s), 1);
    chk_eq("fwd.young_b", int'(b_s), 1);
    tick();

    // Load-use on RB: one stall cycle then MEM forward
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk_ctrl("lu.stall", 0, 0, 1);
    chk_eq("lu.cnt0", int'(stall_cnt), 0);
    tick();
    chk_eq("lu.cnt1", int'(stall_cnt), 1);
    chk_ctrl("lu.resume", 1, 1, 0);
    chk_eq("lu.b_s", int'(b_s), 2);
    chk_eq("lu.a_s", int'(a_s), 0);
    tick();

    // GR0 is never forwarded; unused operand never forwards or stalls
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    chk_eq("gr0.a_s", int'(a_s), 0);
    chk_eq("gr0.b_s", int'(b_s), 0);
    tick();
    set_id(5'd0, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("unused.b_s", int'(b_s), 0);
    chk_ctrl("unused", 1, 1, 0);
    tick();

    // Taken branch overrides load-use; squashed slot (writes r9) must be invalid
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    chk_ctrl("br", 1, 1, 1);
    tick();
    set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("br.cnt", int'(stall_cnt), 1);
    chk_eq("br.squash_a_s", int'(a_s), 2);
    chk_ctrl("br.next", 1, 1, 0);
    tick();

    // Saturation: five more stalls from 1 must stop at 3
    exp_cnt = 1;
    for (int i = 0; i < 5; i++) begin
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(5'd0, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_eq("sat.stall_nop", int'(nop_s), 1);
      tick();
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      chk_eq("sat.cnt", int'(stall_cnt), exp_cnt);
      tick();
    end
    chk_eq("sat.hold", int'(stall_cnt), 3);

    // Reset asserted mid-stall drops the stall
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("mid.stall", 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_ctrl("mid.rst", 0, 0, 1);
    chk_eq("mid.rst_cnt", int'(stall_cnt), 0);
    chk_eq("mid.rst_a_s", int'(a_s), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_ctrl("mid.rel", 1, 1, 0);
    chk_eq("mid.rel_a_s", int'(a_s), 0);
    tick();
    chk_eq("mid.rel_cnt", int'(stall_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
